// File: rtl/alu_share_ctrl.sv
// Shares one 16-bit ALU between two valid/ready requesters. Results land in a one-entry response buffer.
// The buffer has 1-cycle latency and accepts 1 op/cycle; a full, undrained buffer blocks all grants.
module alu_share_ctrl #(
  parameter int PRIO_MODE = 0,
  parameter int FLAG_REQ  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [15:0] r0_in1,
  input  logic [15:0] r0_in2,
  input  logic [2:0]  r0_op,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [15:0] r1_in1,
  input  logic [15:0] r1_in2,
  input  logic [2:0]  r1_op,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_out,
  input  logic [2:0]  alu_flag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic [2:0]  flag_reg
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic FLAG_ID = 1'(FLAG_REQ);

  state_t      state_q, state_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_id_q, rsp_id_d;
  logic [2:0]  flag_q, flag_d;
  logic        last_grant_q, last_grant_d;

  logic slot_free, gnt0, gnt1, accept;

  always_comb begin
    slot_free = (state_q == EMPTY) || rsp_ready;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && slot_free) begin
      if (PRIO_MODE == 1) begin
        if (r0_valid)      gnt0 = 1'b1;
        else if (r1_valid) gnt1 = 1'b1;
      end else if (r0_valid && r1_valid) begin
        // Contention goes to whoever did not win last time.
        gnt0 = last_grant_q;
        gnt1 = !last_grant_q;
      end else begin
        gnt0 = r0_valid;
        gnt1 = r1_valid;
      end
    end
    accept = gnt0 || gnt1;
  end

  // Operands are muxed only by the grant so an idle requester's inputs never reach the ALU.
  always_comb begin
    alu_in1 = 16'h0000;
    alu_in2 = 16'h0000;
    alu_op  = 3'b000;
    if (gnt0) begin
      alu_in1 = r0_in1;
      alu_in2 = r0_in2;
      alu_op  = r0_op;
    end else if (gnt1) begin
      alu_in1 = r1_in1;
      alu_in2 = r1_in2;
      alu_op  = r1_op;
    end
  end

  always_comb begin
    state_d      = state_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    flag_d       = flag_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      state_d      = FULL;
      rsp_data_d   = alu_out;
      rsp_id_d     = gnt1;
      last_grant_d = gnt1;
      if (gnt1 == FLAG_ID) begin
        // ALU flags describe the adder only; logic/shift ops derive Z locally.
        case (alu_op)
          3'b000, 3'b001:                 flag_d    = alu_flag;
          3'b011, 3'b100, 3'b101, 3'b110: flag_d[1] = (alu_out == 16'h0000);
          default:                        flag_d    = flag_q;
        endcase
      end
    end else if (rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      rsp_data_q   <= 16'h0000;
      rsp_id_q     <= 1'b0;
      flag_q       <= 3'b000;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      flag_q       <= flag_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign r0_ready  = gnt0;
  assign r1_ready  = gnt1;
  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign flag_reg  = flag_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Runs a round-robin and a fixed-priority instance side by side, each with its own ALU and requesters.
// Every cycle both are compared against a transaction-level reference model.
module tb_alu_share_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        rv   [2][2];
  logic [15:0] a1   [2][2];
  logic [15:0] a2   [2][2];
  logic [2:0]  op   [2][2];
  logic        rdy  [2][2];
  logic        rr   [2];
  logic [15:0] ain1 [2];
  logic [15:0] ain2 [2];
  logic [2:0]  aop  [2];
  logic [15:0] aout [2];
  logic [2:0]  aflg [2];
  logic        rsv  [2];
  logic        rid  [2];
  logic [15:0] rdat [2];
  logic [2:0]  flg  [2];

  // Reference ALU: returns {N,Z,V,result}; flags always come from the adder (a+b, or a-b for SUB).
  function automatic logic [18:0] alu_f(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] bb, sum, r;
    logic [31:0] rot;
    int s;
    bb  = (o == 3'd1) ? ~b : b;
    sum = a + bb + {15'd0, (o == 3'd1)};
    rot = {a, a} >> b[3:0];
    case (o)
      3'd0, 3'd1: r = sum;
      3'd2: r = {15'd0, ^a};
      3'd3: r = a ^ b;
      3'd4: r = a << b[3:0];
      3'd5: r = 16'($signed(a) >>> b[3:0]);
      3'd6: r = rot[15:0];
      default: begin
        for (int i = 0; i < 2; i++) begin
          s = int'($signed(a[8*i +: 8])) + int'($signed(b[8*i +: 8]));
          if (s > 127)  s = 127;
          if (s < -128) s = -128;
          r[8*i +: 8] = s[7:0];
        end
      end
    endcase
    return {sum[15], sum == 16'h0000, (a[15] == bb[15]) && (sum[15] != a[15]), r};
  endfunction

  assign {aflg[0], aout[0]} = alu_f(aop[0], ain1[0], ain2[0]);
  assign {aflg[1], aout[1]} = alu_f(aop[1], ain1[1], ain2[1]);

  alu_share_ctrl #(.PRIO_MODE(0), .FLAG_REQ(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(rv[0][0]), .r0_ready(rdy[0][0]), .r0_in1(a1[0][0]), .r0_in2(a2[0][0]), .r0_op(op[0][0]),
    .r1_valid(rv[0][1]), .r1_ready(rdy[0][1]), .r1_in1(a1[0][1]), .r1_in2(a2[0][1]), .r1_op(op[0][1]),
    .alu_in1(ain1[0]), .alu_in2(ain2[0]), .alu_op(aop[0]), .alu_out(aout[0]), .alu_flag(aflg[0]),
    .rsp_valid(rsv[0]), .rsp_ready(rr[0]), .rsp_id(rid[0]), .rsp_data(rdat[0]), .flag_reg(flg[0])
  );

  alu_share_ctrl #(.PRIO_MODE(1), .FLAG_REQ(0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(rv[1][0]), .r0_ready(rdy[1][0]), .r0_in1(a1[1][0]), .r0_in2(a2[1][0]), .r0_op(op[1][0]),
    .r1_valid(rv[1][1]), .r1_ready(rdy[1][1]), .r1_in1(a1[1][1]), .r1_in2(a2[1][1]), .r1_op(op[1][1]),
    .alu_in1(ain1[1]), .alu_in2(ain2[1]), .alu_op(aop[1]), .alu_out(aout[1]), .alu_flag(aflg[1]),
    .rsp_valid(rsv[1]), .rsp_ready(rr[1]), .rsp_id(rid[1]), .rsp_data(rdat[1]), .flag_reg(flg[1])
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model state per instance (index 0 = round-robin, 1 = fixed priority).
  logic        mv [2];
  logic        mid [2];
  logic [15:0] mdata [2];
  logic [2:0]  mflag [2];
  logic        mlast [2];
  int          gm [2];

  function automatic int model_grant(input int m);
    if (!rst_n) return -1;
    if (mv[m] && !rr[m]) return -1;
    if (m == 1 || !(rv[m][0] && rv[m][1])) return rv[m][0] ? 0 : (rv[m][1] ? 1 : -1);
    return mlast[m] ? 0 : 1;
  endfunction

  task automatic tick(input bit en);
    logic [18:0] f;
    int g;
    #1;
    for (int m = 0; m < 2; m++) begin
      g = model_grant(m);
      gm[m] = g;
      if (en) begin
        chk($sformatf("m%0d_r0_ready", m), rdy[m][0], g == 0);
        chk($sformatf("m%0d_r1_ready", m), rdy[m][1], g == 1);
        chk($sformatf("m%0d_alu_in1", m), ain1[m], (g < 0) ? 16'h0 : a1[m][g]);
        chk($sformatf("m%0d_alu_in2", m), ain2[m], (g < 0) ? 16'h0 : a2[m][g]);
        chk($sformatf("m%0d_alu_op", m), aop[m], (g < 0) ? 3'h0 : op[m][g]);
        chk($sformatf("m%0d_rsp_valid", m), rsv[m], mv[m]);
        chk($sformatf("m%0d_rsp_id", m), rid[m], mid[m]);
        chk($sformatf("m%0d_rsp_data", m), rdat[m], mdata[m]);
        chk($sformatf("m%0d_flag_reg", m), flg[m], mflag[m]);
      end
      if (!rst_n) begin
        mv[m] = 0; mid[m] = 0; mdata[m] = 0; mflag[m] = 0; mlast[m] = 1;
      end else if (g >= 0) begin
        f = alu_f(op[m][g], a1[m][g], a2[m][g]);
        mv[m] = 1; mid[m] = g[0]; mdata[m] = f[15:0]; mlast[m] = g[0];
        if (g == 0) begin
          if (op[m][g] <= 3'd1) mflag[m] = f[18:16];
          else if (op[m][g] >= 3'd3 && op[m][g] <= 3'd6) mflag[m][1] = (f[15:0] == 16'h0);
        end
      end else if (rr[m]) begin
        mv[m] = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v0, input logic [15:0] x0, input logic [15:0] y0, input logic [2:0] o0,
                       input logic v1, input logic [15:0] x1, input logic [15:0] y1, input logic [2:0] o1,
                       input logic r);
    for (int m = 0; m < 2; m++) begin
      rv[m][0] = v0; a1[m][0] = x0; a2[m][0] = y0; op[m][0] = o0;
      rv[m][1] = v1; a1[m][1] = x1; a2[m][1] = y1; op[m][1] = o1;
      rr[m] = r;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0);
    rst_n = 1'b1;
    for (int m = 0; m < 2; m++) begin
      chk("reset_rsp_valid", rsv[m], 0);
      chk("reset_flag_reg", flg[m], 0);
      chk("reset_rsp_data", rdat[m], 0);
    end

    // Single ADD overflowing into the sign bit.
    drive(1, 16'h7FFF, 16'h0001, 3'd0, 0, 0, 0, 0, 1);
    tick(1);
    chk("add_rsp_valid", rsv[0], 1);
    chk("add_rsp_id", rid[0], 0);
    chk("add_rsp_data", rdat[0], 16'h8000);
    chk("add_flags", flg[0], 3'b101);

    // Contention: round-robin alternates (r0 just won, so r1 goes next); fixed priority keeps r0.
    drive(1, 16'd1, 16'd1, 3'd0, 1, 16'd2, 16'd2, 3'd0, 1);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("rr_rsp_id", rid[0], (i % 2 == 0) ? 1 : 0);
      chk("fp_rsp_id", rid[1], 0);
    end
    drive(0, 0, 0, 0, 1, 16'd2, 16'd2, 3'd0, 1);
    tick(1);
    chk("fp_r1_after_r0_drop", rid[1], 1);

    // Backpressure with a pending r0 op.
    drive(1, 16'h1234, 16'h0000, 3'd3, 0, 0, 0, 0, 1);
    tick(1);
    drive(1, 16'd1, 16'd2, 3'd0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("bp_hold_data", rdat[0], 16'h1234);
    end
    rr[0] = 1; rr[1] = 1;
    tick(1);
    chk("bp_new_data", rdat[0], 16'h0003);

    // Flag classes.
    drive(1, 16'h7FFF, 16'h0001, 3'd0, 0, 0, 0, 0, 1);
    tick(1);
    chk("flag_start", flg[0], 3'b101);
    drive(1, 16'h00FF, 16'h00FF, 3'd3, 0, 0, 0, 0, 1);
    tick(1);
    chk("flag_xor", flg[0], 3'b111);
    drive(1, 16'h7F7F, 16'h0101, 3'd7, 0, 0, 0, 0, 1);
    tick(1);
    chk("flag_paddsb", flg[0], 3'b111);
    chk("paddsb_data", rdat[0], 16'h7F7F);
    drive(0, 0, 0, 0, 1, 16'd5, 16'd5, 3'd1, 1);
    tick(1);
    chk("flag_r1_sub", flg[0], 3'b111);
    drive(1, 16'd5, 16'd5, 3'd1, 0, 0, 0, 0, 1);
    tick(1);
    chk("flag_r0_sub", flg[0], 3'b010);

    // Reset in the middle of a full, stalled buffer.
    drive(1, 16'h7FFF, 16'h0001, 3'd0, 0, 0, 0, 0, 1);
    tick(1);
    drive(1, 16'h00FF, 16'h00FF, 3'd3, 0, 0, 0, 0, 1);
    tick(1);
    drive(1, 16'd3, 16'd4, 3'd0, 1, 16'd5, 16'd6, 3'd0, 0);
    tick(1);
    chk("pre_rst_flags", flg[0], 3'b111);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("mid_rst_valid", rsv[0], 0);
    chk("mid_rst_flags", flg[0], 0);
    rr[0] = 1; rr[1] = 1;
    #1;
    chk("post_rst_r0_first", rdy[0][0], 1);
    tick(1);

    // Randomized traffic; requesters hold their op until the model says it was granted.
    for (int c = 0; c < 600; c++) begin
      for (int m = 0; m < 2; m++) begin
        for (int r = 0; r < 2; r++) begin
          if (!(rv[m][r] && gm[m] != r)) begin
            rv[m][r] = ($urandom_range(3) != 0);
            a1[m][r] = 16'($urandom);
            a2[m][r] = ($urandom_range(3) == 0) ? a1[m][r] : 16'($urandom);
            op[m][r] = 3'($urandom_range(7));
          end
        end
        rr[m] = ($urandom_range(3) != 0);
      end
      rst_n = ($urandom_range(63) != 0);
      tick(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Arbiter/sequencer that shares the single 16-bit ALU between two requesters over valid/ready handshakes.
  - Requester 0: the execute stage.
  - Requester 1: the address/auxiliary path.
- Drives the ALU operands and 3-bit op, registers each result into a one-entry response buffer, and owns the architectural N/Z/V flag register.
- Flags are updated per opcode class, only for operations issued by the flag-owning requester.

Parameters:
- PRIO_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority (requester 0 always wins).
- FLAG_REQ, 0, id (0 or 1) of the requester whose accepted ops update flag_reg.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- r0_valid  input  1  requester 0 has an op
- r0_ready  output  1  requester 0 op accepted this cycle
- r0_in1  input  16  requester 0 operand 1
- r0_in2  input  16  requester 0 operand 2
- r0_op  input  3  requester 0 ALU op
- r1_valid  input  1  requester 1 has an op
- r1_ready  output  1  requester 1 op accepted this cycle
- r1_in1  input  16  requester 1 operand 1
- r1_in2  input  16  requester 1 operand 2
- r1_op  input  3  requester 1 ALU op
- alu_in1  output  16  to ALU operand 1
- alu_in2  output  16  to ALU operand 2
- alu_op  output  3  to ALU op select
- alu_out  input  16  ALU result (combinational from alu_in*/alu_op)
- alu_flag  input  3  ALU adder flags {N,Z,V}
- rsp_valid  output  1  response buffer holds a result
- rsp_ready  input  1  consumer takes response this cycle
- rsp_id  output  1  requester id of buffered result
- rsp_data  output  16  buffered result
- flag_reg  output  3  architectural flags {N,Z,V}

Behaviour:
- Op encoding: 000 ADD, 001 SUB, 010 RED, 011 XOR, 100 SLL, 101 SRA, 110 ROR, 111 PADDSB.
- Reset (rst_n=0 at clk edge):
  - rsp_valid=0, rsp_id=0, rsp_data=0, flag_reg=000, last_grant=1.
  - Any buffered response is discarded; no op is accepted during a reset cycle.
- Slot free: slot_free = !rsp_valid || rsp_ready.
- Grant (combinational), only when slot_free:
  - PRIO_MODE=1: r0 if r0_valid, else r1.
  - PRIO_MODE=0:
    - Only one valid → that requester wins.
    - Both valid → the requester not equal to last_grant wins.
  - After reset with both valid, r0 is granted first.
- rN_ready = grant to N. At most one ready per cycle. Neither is asserted when the slot is not free.
- Requester obligation: hold valid/operands/op stable until ready. The block does not latch un-granted requests.
- ALU drive:
  - On a grant cycle: alu_in1/alu_in2/alu_op = granted requester's fields.
  - Otherwise: 0/0/000.
- Accept (grant at edge N), effects at edge N:
  - rsp_data <= alu_out, rsp_id <= granted id, rsp_valid <= 1, last_grant <= granted id.
  - Result visible cycle N+1. Latency = 1 cycle, throughput = 1 op/cycle when rsp_ready is held high.
- Drain without new accept: rsp_valid <= 0. Simultaneous drain and accept: rsp_valid stays 1 and loads the new data.
- Backpressure: rsp_valid=1 and rsp_ready=0 → slot not free, no grant, buffer holds all fields unchanged.
- Flag update: only on an accepted op from FLAG_REQ, at the same edge as the response load.
  - ADD/SUB: flag_reg <= alu_flag (N, Z and V all taken from the ALU).
  - XOR/SLL/SRA/ROR: Z <= (alu_out==16'h0000); N and V unchanged. Z is computed here because the ALU flag output reflects the adder only.
  - RED/PADDSB: no change.
  - Ops from the other requester never change flag_reg.
- FSM, 2 states:
  - EMPTY (rsp_valid=0) → FULL on accept; otherwise stays EMPTY.
  - FULL: rsp_ready && !accept → EMPTY; otherwise stays FULL.
- Invalid X/Z on an unselected requester's inputs must not propagate to ALU or flags.

Test Plan:
- Reset then single op: r0 ADD 16'h7FFF+16'h0001, rsp_ready=1 → r0_ready in cycle 1; cycle 2: rsp_valid=1, rsp_id=0, rsp_data=16'h8000, flag_reg=3'b101 (N=1, V=1).
- Round-robin contention, PRIO_MODE=0: both valid every cycle, rsp_ready=1 → grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1 with one result per cycle.
- Fixed priority, PRIO_MODE=1: both valid for 4 cycles → r1_ready never asserted; r1 is granted in the first cycle r0_valid=0.
- Backpressure: buffer full (rsp_data=16'h1234), rsp_ready=0 for 3 cycles with r0 pending → no ready and buffer unchanged. Then rsp_ready=1 → same-cycle accept of r0; next cycle holds the new data.
- Flag classes:
  - Start flag_reg=101.
  - r0 XOR 16'h00FF^16'h00FF → flag_reg=111.
  - r0 PADDSB → unchanged.
  - r1 SUB 5-5 → unchanged.
  - r0 SUB 5-5 → 010.
- Reset mid-operation: buffer full with rsp_valid=1 and flag_reg=111; assert rst_n=0 for one edge → rsp_valid=0, flag_reg=000. With both requesters valid, r0 is granted first after reset.
